// File: rtl/route_compute_mp.sv
// Multi-port route lookup: round-robin arbitration feeds one shared engine that
// scans the routing table LANES entries per cycle and holds one result per port.
module route_compute_mp #(
    parameter  int NODE         = 1,
    parameter  int NUM_INPORTS  = 4,
    parameter  int NUM_OUTPORTS = 4,
    parameter  int LUT_DEPTH    = 32,
    parameter  int LANES        = 8,
    parameter  int ID_W         = 5,
    parameter  int DEFAULT_PORT = 0,
    localparam int SEL_W        = $clog2(NUM_OUTPORTS) + (NUM_OUTPORTS == 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [LUT_DEPTH-1:0]           lut_en,
    input  logic [LUT_DEPTH*ID_W-1:0]      lut_req,
    input  logic [LUT_DEPTH*ID_W-1:0]      lut_dest,
    input  logic [LUT_DEPTH*SEL_W-1:0]     lut_out_sel,
    input  logic [NUM_INPORTS-1:0]         rq_valid,
    output logic [NUM_INPORTS-1:0]         rq_ready,
    input  logic [NUM_INPORTS*ID_W-1:0]    rq_req_id,
    input  logic [NUM_INPORTS*ID_W-1:0]    rq_dest,
    output logic [NUM_INPORTS-1:0]         rsp_valid,
    output logic [NUM_INPORTS*SEL_W-1:0]   rsp_out_sel,
    output logic [NUM_INPORTS-1:0]         rsp_miss,
    input  logic [NUM_INPORTS-1:0]         rsp_ack,
    output logic                           busy
);

    localparam int BEATS  = LUT_DEPTH / LANES;
    localparam int BEAT_W = $clog2(BEATS) + (BEATS == 1);
    localparam int PORT_W = $clog2(NUM_INPORTS) + (NUM_INPORTS == 1);

    typedef enum logic {IDLE, SCAN} state_e;

    state_e                            state_q, state_d;
    logic [BEAT_W-1:0]                 beat_q, beat_d;
    logic [PORT_W-1:0]                 rr_q, rr_d;
    logic [PORT_W-1:0]                 port_q, port_d;
    logic [ID_W-1:0]                   req_id_q, req_id_d;
    logic [ID_W-1:0]                   dest_q, dest_d;
    logic [NUM_INPORTS-1:0]            rsp_valid_q, rsp_valid_d;
    logic [NUM_INPORTS-1:0]            rsp_miss_q, rsp_miss_d;
    logic [NUM_INPORTS-1:0][SEL_W-1:0] rsp_sel_q, rsp_sel_d;

    logic [NUM_INPORTS-1:0] eligible;
    logic                   grant_any;
    logic [PORT_W-1:0]      grant_idx;
    logic [ID_W-1:0]        grant_req, grant_dest;
    logic                   hit_found;
    logic [SEL_W-1:0]       hit_sel;
    logic                   wr_en;
    logic [PORT_W-1:0]      wr_port;
    logic [SEL_W-1:0]       wr_sel;
    logic                   wr_miss;

    // A port whose held result is being acked this cycle may be re-granted at once.
    assign eligible = rq_valid & (~rsp_valid_q | rsp_ack);

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_INPORTS; k++) begin
            if (!grant_any && eligible[(int'(rr_q) + k) % NUM_INPORTS]) begin
                grant_any = 1'b1;
                grant_idx = PORT_W'((int'(rr_q) + k) % NUM_INPORTS);
            end
        end
    end

    assign grant_req  = rq_req_id[grant_idx*ID_W +: ID_W];
    assign grant_dest = rq_dest[grant_idx*ID_W +: ID_W];

    function automatic logic entry_hit(input int e);
        logic [ID_W-1:0] ent_req;
        logic [ID_W-1:0] ent_dest;
        ent_req  = lut_req[e*ID_W +: ID_W];
        ent_dest = lut_dest[e*ID_W +: ID_W];
        return lut_en[e]
            && (ent_req == '0 || ent_req == req_id_q)
            && (ent_dest == '0 || dest_q == '0 || ent_dest == dest_q);
    endfunction

    // Ascending scan with a found flag: the lowest-index hit in the beat wins.
    always_comb begin
        hit_found = 1'b0;
        hit_sel   = '0;
        for (int l = 0; l < LANES; l++) begin
            if (!hit_found && entry_hit(int'(beat_q) * LANES + l)) begin
                hit_found = 1'b1;
                hit_sel   = lut_out_sel[(int'(beat_q) * LANES + l)*SEL_W +: SEL_W];
            end
        end
    end

    // NOTE: every output of this block gets a default up front so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        rr_d     = rr_q;
        port_d   = port_q;
        req_id_d = req_id_q;
        dest_d   = dest_q;
        rq_ready = '0;
        wr_en    = 1'b0;
        wr_port  = port_q;
        wr_sel   = '0;
        wr_miss  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    rq_ready[grant_idx] = 1'b1;
                    rr_d     = PORT_W'((int'(grant_idx) + 1) % NUM_INPORTS);
                    port_d   = grant_idx;
                    req_id_d = grant_req;
                    dest_d   = grant_dest;
                    if (grant_dest == ID_W'(NODE)) begin
                        wr_en   = 1'b1;
                        wr_port = grant_idx;
                    end else begin
                        state_d = SCAN;
                        beat_d  = '0;
                    end
                end
            end
            SCAN: begin
                if (hit_found) begin
                    wr_en   = 1'b1;
                    wr_sel  = hit_sel;
                    state_d = IDLE;
                end else if (beat_q == BEAT_W'(BEATS - 1)) begin
                    wr_en   = 1'b1;
                    wr_sel  = SEL_W'(DEFAULT_PORT);
                    wr_miss = 1'b1;
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A result write for a port overrides an ack arriving in the same cycle.
    always_comb begin
        rsp_valid_d = rsp_valid_q & ~rsp_ack;
        rsp_sel_d   = rsp_sel_q;
        rsp_miss_d  = rsp_miss_q;
        if (wr_en) begin
            rsp_valid_d[wr_port] = 1'b1;
            rsp_sel_d[wr_port]   = wr_sel;
            rsp_miss_d[wr_port]  = wr_miss;
        end
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            rr_q        <= '0;
            port_q      <= '0;
            req_id_q    <= '0;
            dest_q      <= '0;
            rsp_valid_q <= '0;
            rsp_sel_q   <= '0;
            rsp_miss_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            rr_q        <= rr_d;
            port_q      <= port_d;
            req_id_q    <= req_id_d;
            dest_q      <= dest_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sel_q   <= rsp_sel_d;
            rsp_miss_q  <= rsp_miss_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_out_sel = rsp_sel_q;
    assign rsp_miss    = rsp_miss_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_route_compute_mp.sv
// Scoreboard bench for route_compute_mp: stimulus pushes expected results with
// their arrival cycle; a negedge monitor pops and compares each new result.
module tb_route_compute_mp;

    localparam int NODE  = 1;
    localparam int NIN   = 4;
    localparam int DEPTH = 32;
    localparam int LANES = 8;
    localparam int ID_W  = 5;
    localparam int SEL_W = 2;
    localparam int DEFP  = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DEPTH-1:0]      lut_en;
    logic [DEPTH*ID_W-1:0] lut_req;
    logic [DEPTH*ID_W-1:0] lut_dest;
    logic [DEPTH*SEL_W-1:0] lut_out_sel;
    logic [NIN-1:0]        rq_valid;
    logic [NIN-1:0]        rq_ready;
    logic [NIN*ID_W-1:0]   rq_req_id;
    logic [NIN*ID_W-1:0]   rq_dest;
    logic [NIN-1:0]        rsp_valid;
    logic [NIN*SEL_W-1:0]  rsp_out_sel;
    logic [NIN-1:0]        rsp_miss;
    logic [NIN-1:0]        rsp_ack;
    logic                  busy;

    route_compute_mp #(
        .NODE(NODE), .NUM_INPORTS(NIN), .NUM_OUTPORTS(4), .LUT_DEPTH(DEPTH),
        .LANES(LANES), .ID_W(ID_W), .DEFAULT_PORT(DEFP)
    ) dut (
        .clk(clk), .rst(rst),
        .lut_en(lut_en), .lut_req(lut_req), .lut_dest(lut_dest), .lut_out_sel(lut_out_sel),
        .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_req_id(rq_req_id), .rq_dest(rq_dest),
        .rsp_valid(rsp_valid), .rsp_out_sel(rsp_out_sel), .rsp_miss(rsp_miss),
        .rsp_ack(rsp_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int port;
        int sel;
        int miss;
        int cyc;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           mon_e;
    int             checks   = 0;
    int             failures = 0;
    int             cyc      = 0;
    logic [NIN-1:0] prev_valid = '0;
    logic [NIN-1:0] prev_ack   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A result is new when rsp_valid rises, or stays high across an ack (rewrite).
    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NIN; p++) begin
                if (rsp_valid[p] && (!prev_valid[p] || prev_ack[p])) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rsp: port %0d produced a result, none expected (cycle %0d)", p, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("rsp_port", 32'(p), 32'(mon_e.port));
                        check("rsp_sel", 32'(rsp_out_sel[p*SEL_W +: SEL_W]), 32'(mon_e.sel));
                        check("rsp_miss", 32'(rsp_miss[p]), 32'(mon_e.miss));
                        check("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
                    end
                end
            end
        end
        prev_valid <= rsp_valid;
        prev_ack   <= rsp_ack;
    end

    task automatic lut_clear();
        lut_en = '0; lut_req = '0; lut_dest = '0; lut_out_sel = '0;
    endtask

    task automatic lut_set(input int i, input int req, input int dest, input int sel);
        lut_en[i]                    = 1'b1;
        lut_req[i*ID_W +: ID_W]      = ID_W'(req);
        lut_dest[i*ID_W +: ID_W]     = ID_W'(dest);
        lut_out_sel[i*SEL_W +: SEL_W] = SEL_W'(sel);
    endtask

    task automatic set_port(input int p, input int req, input int dest);
        rq_req_id[p*ID_W +: ID_W] = ID_W'(req);
        rq_dest[p*ID_W +: ID_W]   = ID_W'(dest);
    endtask

    // Called just after a posedge; lat==0 means no result is expected.
    task automatic request(input int p, input int req, input int dest,
                           input int sel, input int miss, input int lat);
        rq_valid = '0;
        rq_valid[p] = 1'b1;
        set_port(p, req, dest);
        @(negedge clk);
        check("rq_ready_accept", 32'(rq_ready), 32'(1 << p));
        if (lat > 0) exp_q.push_back('{p, sel, miss, cyc + lat});
        @(posedge clk); #1;
        rq_valid = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic ack_port(input int p);
        rsp_ack = '0;
        rsp_ack[p] = 1'b1;
        @(posedge clk); #1;
        rsp_ack = '0;
    endtask

    // Round-robin/backpressure steps: ack vector driven and rq_ready expected.
    logic [NIN-1:0] rr_ack [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1101,
                                   4'b0000, 4'b0000, 4'b0000, 4'b0010};
    logic [NIN-1:0] rr_rdy [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                   4'b0100, 4'b1000, 4'b0000, 4'b0010};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rq_valid = '0; rq_req_id = '0; rq_dest = '0; rsp_ack = '0;
        lut_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_sel", 32'(rsp_out_sel), 32'd0);
        check("reset_rsp_miss", 32'(rsp_miss), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rq_ready", 32'(rq_ready), 32'd0);
        @(posedge clk); #1;

        // Local fast path, result held until ack.
        request(0, 3, NODE, 0, 0, 1);
        drain();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("hold_valid", 32'(rsp_valid[0]), 32'd1);
        check("hold_sel", 32'(rsp_out_sel[1:0]), 32'd0);
        @(posedge clk); #1;
        ack_port(0);
        @(negedge clk);
        check("ack_clears", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk); #1;

        // Match in beat 2; no accept while scanning.
        lut_clear();
        lut_set(17, 0, 5, 3);
        request(2, 7, 5, 3, 0, 4);
        rq_valid[0] = 1'b1;
        set_port(0, 3, NODE);
        @(negedge clk);
        check("scan_busy", 32'(busy), 32'd1);
        check("scan_no_ready", 32'(rq_ready), 32'd0);
        @(posedge clk); #1;
        rq_valid = '0;
        drain();
        ack_port(2);

        // Priority: earlier beat wins; requester mismatch falls to wildcard entry.
        lut_clear();
        lut_set(3, 2, 6, 1);
        lut_set(20, 0, 0, 2);
        request(1, 2, 6, 1, 0, 2);
        drain();
        ack_port(1);
        request(1, 4, 6, 2, 0, 4);
        drain();
        ack_port(1);

        // Miss fallback after all four beats.
        lut_clear();
        request(3, 9, 12, DEFP, 1, 5);
        drain();
        ack_port(3);

        // Round-robin and backpressure on the fast path.
        rq_valid = '1;
        for (int p = 0; p < NIN; p++) set_port(p, p + 2, NODE);
        for (int s = 0; s < 9; s++) begin
            rsp_ack = rr_ack[s];
            @(negedge clk);
            check($sformatf("rr_ready_step%0d", s), 32'(rq_ready), 32'(rr_rdy[s]));
            for (int p = 0; p < NIN; p++)
                if (rr_rdy[s][p]) exp_q.push_back('{p, 0, 0, cyc + 1});
            @(posedge clk); #1;
        end
        rsp_ack = '0;
        rq_valid = '0;
        drain();

        // Reset mid-scan while other ports hold results.
        ack_port(2);
        request(2, 9, 12, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midscan_rst_valid", 32'(rsp_valid), 32'd0);
        check("midscan_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Normal lookups after reset, including a wildcard request dest.
        lut_clear();
        lut_set(9, 0, 8, 2);
        lut_set(17, 0, 5, 3);
        request(2, 7, 5, 3, 0, 4);
        drain();
        request(1, 7, 0, 2, 0, 3);
        drain();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/route_compute_mp.md
Name: route_compute_mp

Overview:
- Shared, multi-port successor to the single-port route lookup in the switch.
- Serves NUM_INPORTS input ports through one round-robin-arbitrated lookup engine.
- Scans a LUT_DEPTH-entry routing table LANES entries per cycle, so lookup latency trades against comparator area.
- Each port holds a result register (out_sel, miss flag) until acknowledged. Table misses fall back to a default port and are flagged instead of silently returning 0.

Parameters:
- NODE, 1, this switch's node ID; dest==NODE routes to port 0.
- NUM_INPORTS, 4, number of requesting input ports.
- NUM_OUTPORTS, 4, number of output ports. SEL_W = $clog2(NUM_OUTPORTS) + (NUM_OUTPORTS==1).
- LUT_DEPTH, 32, routing table entries. Must be a multiple of LANES.
- LANES, 8, table entries compared per scan cycle. BEATS = LUT_DEPTH/LANES.
- ID_W, 5, node ID width.
- DEFAULT_PORT, 0, out_sel returned on a table miss.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- lut_en  in  LUT_DEPTH  per-entry valid.
- lut_req  in  LUT_DEPTH*ID_W  entry requester ID; 0 = wildcard.
- lut_dest  in  LUT_DEPTH*ID_W  entry destination ID; 0 = wildcard.
- lut_out_sel  in  LUT_DEPTH*SEL_W  entry output select.
- rq_valid  in  NUM_INPORTS  port has a head flit needing a route.
- rq_ready  out  NUM_INPORTS  one-hot accept, combinational.
- rq_req_id  in  NUM_INPORTS*ID_W  per-port requester ID.
- rq_dest  in  NUM_INPORTS*ID_W  per-port destination ID.
- rsp_valid  out  NUM_INPORTS  result held for this port.
- rsp_out_sel  out  NUM_INPORTS*SEL_W  result output select.
- rsp_miss  out  NUM_INPORTS  result came from the DEFAULT_PORT fallback.
- rsp_ack  in  NUM_INPORTS  consumer pops the result.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset values: rsp_valid=0, rsp_out_sel=0, rsp_miss=0, busy=0, FSM=IDLE, rr_ptr=0, beat=0. Reset asserted mid-scan aborts the lookup and discards the latched request.
- Eligibility: port p is eligible when rq_valid[p] && !rsp_valid[p] (or rsp_ack[p] this cycle).
- Arbitration (IDLE only): grant the first eligible port at or after rr_ptr, wrapping. rq_ready[grant]=1 that cycle only.
- On grant: latch req_id, dest and port index. rr_ptr <= grant+1 mod NUM_INPORTS.
- Local fast path: if latched dest==NODE, write result out_sel=0, miss=0 in the next cycle. rsp_valid rises at t+1 (t = accept cycle). FSM stays IDLE, so a new accept can happen at t+1.
- Otherwise FSM -> SCAN, beat=0.
- SCAN, beat b: compare entries [b*LANES, b*LANES+LANES-1]. Entry i matches when all hold:
  - lut_en[i];
  - lut_req[i]==0 or lut_req[i]==req_id;
  - lut_dest[i]==0 or dest==0 or lut_dest[i]==dest.
- Lowest matching index within the beat wins; earlier beats always take priority over later ones.
- On match in beat b: result register written at the clock edge ending beat b, so rsp_valid rises at t+2+b. FSM -> IDLE.
- No match and b==BEATS-1: write out_sel=DEFAULT_PORT, miss=1; rsp_valid rises at t+1+BEATS. FSM -> IDLE.
- No match otherwise: beat++.
- Throughput: no accept while in SCAN; rq_ready=0 there.
- Response hold: rsp_valid/out_sel/miss stay stable until rsp_ack.
  - rsp_ack with rsp_valid=0 is ignored.
  - If ack and a new result write hit the same port in the same cycle, the write wins and rsp_valid stays 1. This only happens on the fast path for a port that was eligible via ack.
- Table is sampled live each beat. Table changes during busy=1 give a result from mixed beats; software must gate updates on busy.
- LUT_DEPTH==LANES: BEATS=1, non-local latency is 2 cycles.

Test Plan:
- Local fast path: NODE=1, port 0 requests dest=1 at cycle 0 -> rq_ready[0]=1 at 0; rsp_valid[0]=1, out_sel=0, miss=0 at cycle 1; holds until rsp_ack.
- Match in beat 2: LANES=8, only entry 17 = {en=1, req=0, dest=5, sel=3}; port 2 requests dest=5 -> rsp_valid[2] at t+4, out_sel=3, miss=0.
- Priority: entries 3 {req=2, dest=6, sel=1} and 20 {req=0, dest=0, sel=2}; request req=2, dest=6 -> out_sel=1 at t+2. Request req=4, dest=6 -> out_sel=2 at t+4.
- Miss fallback: all lut_en=0, DEFAULT_PORT=3 -> out_sel=3, miss=1 at t+1+BEATS = t+5.
- Round-robin and backpressure:
  - All 4 ports assert rq_valid with dest=NODE -> grants 0,1,2,3 on consecutive cycles.
  - Port 1 left un-acked and re-requesting -> skipped until ack; port 1 is granted in the same cycle its rsp_ack arrives.
- Reset mid-scan: rst pulsed at t+2 of a 4-beat scan -> all rsp_valid=0, busy=0 immediately (asynchronous). The next request after release completes normally.
